aes_round_sequencer: RTL

Parametrised AES round controller that sequences the AddRoundKey, (Inv)SubBytes, (Inv)ShiftRows and (Inv)MixColumns step units for both encryption and decryption and for AES-128/192/256 round counts. It sits between the top-level cipher wrapper, which supplies Start and the input block, and the four step units and the key-schedule mux, which SelKey drives. It adds the following features:

- mode select;
- a start/busy/done handshake;
- a per-step ready timeout;
- an abort input.

---
 rtl/aes_round_sequencer.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/aes_round_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : aes_round_sequencer                                              |
// | Purpose  : Steps AddRoundKey/(Inv)SubBytes/(Inv)ShiftRows/(Inv)MixColumns   |
// |            units through a full AES encrypt or decrypt, NR = 10/12/14.      |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
module aes_round_sequencer #(
  parameter int NR      = 10,
  parameter int TIMEOUT = 255
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         Start,
  input  logic         Mode,
  input  logic         Abort,
  input  logic [127:0] InText,
  output logic         Busy,
  output logic         Done,
  output logic         Err,
  output logic [127:0] OutText,
  output logic [3:0]   SelKey,
  output logic [3:0]   StepEn,
  output logic         StepInv,
  output logic [127:0] Text,
  input  logic [3:0]   StepRy,
  input  logic [127:0] AddText,
  input  logic [127:0] SubText,
  input  logic [127:0] ShiftText,
  input  logic [127:0] MixText
);

  localparam int NSTEPS = 4 * NR;
  localparam int CW     = $clog2(NSTEPS + 1);
  localparam int TW     = 8;

  localparam logic [3:0]    EN_ADD     = 4'b0001;
  localparam logic [3:0]    EN_SUB     = 4'b0010;
  localparam logic [3:0]    EN_SHIFT   = 4'b0100;
  localparam logic [3:0]    EN_MIX     = 4'b1000;
  localparam logic [CW-1:0] LAST_STEP  = CW'(NSTEPS - 1);
  localparam logic [3:0]    KEY_LAST   = 4'(NR);
  localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_STEP  = 2'd1,
    S_GAP   = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          mode_q, mode_d;
  logic [3:0]    step_en_q, step_en_d;
  logic [3:0]    sel_key_q, sel_key_d;
  logic [127:0]  text_q, text_d;
  logic [127:0]  out_text_q, out_text_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] to_q, to_d;

  logic          hit;
  logic [127:0]  cap_text;

  // Step index -> one-hot enable. After the leading Add, both directions
  // repeat a 4-step pattern; encrypt swaps its last Mix for the final Add.
  function automatic logic [3:0] step_of(input logic [CW-1:0] idx, input logic inv);
    logic [1:0] ph;
    ph = idx[1:0] - 2'd1;
    step_of = EN_ADD;
    if (idx == '0 || (!inv && idx == LAST_STEP)) begin
      step_of = EN_ADD;
    end else if (!inv) begin
      case (ph)
        2'd0:    step_of = EN_SUB;
        2'd1:    step_of = EN_SHIFT;
        2'd2:    step_of = EN_MIX;
        default: step_of = EN_ADD;
      endcase
    end else begin
      case (ph)
        2'd0:    step_of = EN_SHIFT;
        2'd1:    step_of = EN_SUB;
        2'd2:    step_of = EN_ADD;
        default: step_of = EN_MIX;
      endcase
    end
  endfunction

  assign hit = |(StepRy & step_en_q);

  always_comb begin
    cap_text = AddText;
    case (step_en_q)
      EN_SUB:   cap_text = SubText;
      EN_SHIFT: cap_text = ShiftText;
      EN_MIX:   cap_text = MixText;
      default:  cap_text = AddText;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    mode_d     = mode_q;
    step_en_d  = step_en_q;
    sel_key_d  = sel_key_q;
    text_d     = text_q;
    out_text_d = out_text_q;
    cnt_d      = cnt_q;
    to_d       = to_q;

    if (state_q != S_IDLE && Abort) begin
      state_d   = S_IDLE;
      busy_d    = 1'b0;
      step_en_d = 4'b0000;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (Start) begin
            state_d   = S_STEP;
            busy_d    = 1'b1;
            mode_d    = Mode;
            text_d    = InText;
            cnt_d     = '0;
            to_d      = '0;
            step_en_d = EN_ADD;
            sel_key_d = Mode ? KEY_LAST : 4'd0;
          end
        end
        S_STEP: begin
          if (hit) begin
            text_d    = cap_text;
            cnt_d     = cnt_q + CW'(1);
            step_en_d = 4'b0000;
            if (cnt_q == LAST_STEP) begin
              state_d    = S_FIN;
              out_text_d = cap_text;
              done_d     = 1'b1;
              busy_d     = 1'b0;
            end else begin
              state_d = S_GAP;
              // Advance the key only after an Add, so it never moves under an active Add
              if (step_en_q == EN_ADD) begin
                sel_key_d = mode_q ? (sel_key_q - 4'd1) : (sel_key_q + 4'd1);
              end
            end
          end else if (to_q == TO_LAST) begin
            state_d   = S_IDLE;
            err_d     = 1'b1;
            busy_d    = 1'b0;
            step_en_d = 4'b0000;
          end else begin
            to_d = to_q + TW'(1);
          end
        end
        S_GAP: begin
          state_d   = S_STEP;
          step_en_d = step_of(cnt_q, mode_q);
          to_d      = '0;
        end
        S_FIN: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      mode_q     <= 1'b0;
      step_en_q  <= 4'b0000;
      sel_key_q  <= 4'd0;
      text_q     <= '0;
      out_text_q <= '0;
      cnt_q      <= '0;
      to_q       <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      mode_q     <= mode_d;
      step_en_q  <= step_en_d;
      sel_key_q  <= sel_key_d;
      text_q     <= text_d;
      out_text_q <= out_text_d;
      cnt_q      <= cnt_d;
      to_q       <= to_d;
    end
  end

  assign Busy    = busy_q;
  assign Done    = done_q;
  assign Err     = err_q;
  assign OutText = out_text_q;
  assign SelKey  = sel_key_q;
  assign StepEn  = step_en_q;
  assign StepInv = mode_q;
  assign Text    = text_q;

endmodule
`default_nettype wire
